// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared sizing constants and types for the 32x64 integer
//                register file.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH = 64;
  localparam int REGFILE_NUM_REGS   = 32;
  localparam int REGFILE_ADDR_WIDTH = 5;
  localparam int REGFILE_ZERO_REG   = 31;

  typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_decoder
//  Description : Turns a write address plus enable into a one-hot per-entry
//                write-enable vector. The zero-register bit never asserts.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_decoder
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int ZERO_REG   = REGFILE_ZERO_REG
) (
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_REGS-1:0]   o_we
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_bit
      if (gi == ZERO_REG) begin : g_zero
        // Hardwired-zero entry can never be written.
        assign o_we[gi] = 1'b0;
      end else begin : g_norm
        assign o_we[gi] = i_en && (i_addr == ADDR_WIDTH'(gi));
      end
    end
  endgenerate

endmodule : regfile_write_decoder
`default_nettype wire

// File: rtl/regfile_32x64.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_32x64
//  Description : 32-entry x 64-bit architectural register file. Two
//                combinational read ports with same-cycle write bypass, one
//                synchronous write port, entry 31 hardwired to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_32x64
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int NUM_REGS   = REGFILE_NUM_REGS,
  parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH,
  parameter int ZERO_REG   = REGFILE_ZERO_REG
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_b_i,
  output logic [DATA_WIDTH-1:0] read_data_a_o,
  output logic [DATA_WIDTH-1:0] read_data_b_o
);

  localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_we;
  logic [DATA_WIDTH-1:0] w_mux_a;
  logic [DATA_WIDTH-1:0] w_mux_b;
  logic                  w_byp_a;
  logic                  w_byp_b;

  regfile_write_decoder #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_wdec (
    .i_en   (write_en_i),
    .i_addr (write_addr_i),
    .o_we   (w_we)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_entry
      // Per-entry storage: reset clears, otherwise load only when selected.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          r_regs[gi] <= '0;
        end else if (w_we[gi]) begin
          r_regs[gi] <= write_data_i;
        end
      end
    end
  endgenerate

  // Read selection for both ports; unmatched addresses fall back to zero so
  // the outputs are always fully defined.
  always_comb begin
    w_mux_a = '0;
    w_mux_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_addr_a_i == ADDR_WIDTH'(i)) w_mux_a = r_regs[i];
      if (read_addr_b_i == ADDR_WIDTH'(i)) w_mux_b = r_regs[i];
    end
  end

  // Bypass is held off during reset because the pending write will be dropped.
  assign w_byp_a = write_en_i && !reset_i && (write_addr_i == read_addr_a_i);
  assign w_byp_b = write_en_i && !reset_i && (write_addr_i == read_addr_b_i);

  // Zero-register override takes precedence over both bypass and storage.
  always_comb begin
    if (read_addr_a_i == c_ZERO_ADDR) read_data_a_o = '0;
    else if (w_byp_a)                 read_data_a_o = write_data_i;
    else                              read_data_a_o = w_mux_a;

    if (read_addr_b_i == c_ZERO_ADDR) read_data_b_o = '0;
    else if (w_byp_b)                 read_data_b_o = write_data_i;
    else                              read_data_b_o = w_mux_b;
  end

endmodule : regfile_32x64
`default_nettype wire
